// File: rtl/rv_pkg.sv
// Shared RV core types: data width, register address width, load opcodes and
// the writeback request carried from the arbiter into the regfile port.
package rv_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } ld_op_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    function automatic logic ld_op_known(input logic [2:0] f3);
        return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// Circular synchronous FIFO holding extended load results until the regfile
// write port is free. Pointers wrap modulo DEPTH (a power of two).
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results take the regfile port first, extended load
// returns queue in a FIFO behind them; a scoreboard tracks in-flight loads.
module wb_arbiter
    import rv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = rv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_addr_lo,
    input  logic [XLEN-1:0] ld_data,
    input  logic            ld_issue,
    input  logic [4:0]      ld_issue_rd,
    output logic            alu_stall,
    output logic [31:0]     pend_mask,
    output logic            we,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rd_data
);
    localparam int FW = $bits(wb_req_t);

    ld_op_e              op;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [XLEN-1:0]     ext_data;
    wb_req_t             push_req;
    wb_req_t             head;
    wb_req_t             sel;
    logic                sel_valid;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic [$clog2(DEPTH):0] count;
    logic [31:0]         pend_next;

    always_comb begin
        op = ld_op_known(ld_funct3) ? ld_op_e'(ld_funct3) : LW;
        case (ld_addr_lo)
            2'd0:    byte_sel = ld_data[7:0];
            2'd1:    byte_sel = ld_data[15:8];
            2'd2:    byte_sel = ld_data[23:16];
            default: byte_sel = ld_data[31:24];
        endcase
        half_sel = ld_addr_lo[1] ? ld_data[31:16] : ld_data[15:0];
        case (op)
            LB:      ext_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LBU:     ext_data = {{(XLEN-8){1'b0}}, byte_sel};
            LH:      ext_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            LHU:     ext_data = {{(XLEN-16){1'b0}}, half_sel};
            default: ext_data = ld_data;
        endcase
    end

    assign ld_ready  = !full;
    assign alu_stall = full;
    assign push      = ld_valid && ld_ready;
    assign push_req  = '{rd: ld_rd, data: ext_data};

    wb_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_req),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        pop       = 1'b0;
        sel_valid = 1'b0;
        sel       = '{rd: alu_rd, data: alu_data};
        if (alu_valid) begin
            sel_valid = 1'b1;
        end else if (!empty) begin
            pop       = 1'b1;
            sel_valid = 1'b1;
            sel       = head;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we      <= 1'b0;
            rd      <= '0;
            rd_data <= '0;
        end else if (sel_valid) begin
            we      <= (sel.rd != '0);
            rd      <= sel.rd;
            rd_data <= sel.data;
        end else begin
            we      <= 1'b0;
        end
    end

    // Set applied after clear so a same-cycle reissue to the retiring register stays pending.
    always_comb begin
        pend_next = pend_mask;
        if (pop) pend_next[head.rd] = 1'b0;
        if (ld_issue) pend_next[ld_issue_rd] = 1'b1;
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_mask <= '0;
        else        pend_mask <= pend_next;
    end

    a_alu_while_stall: assert property (@(posedge clk) disable iff (!rst_n)
        !(alu_valid && alu_stall));
    a_ld_op_known: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> ld_op_known(ld_funct3));
    a_issue_pending: assert property (@(posedge clk) disable iff (!rst_n)
        (ld_issue && ld_issue_rd != '0 && pend_mask[ld_issue_rd])
            |-> (pop && head.rd == ld_issue_rd));
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: extension, arbitration order, FIFO backpressure,
// scoreboard set/clear and reset mid-operation.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic [31:0] ld_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        alu_stall;
    logic [31:0] pend_mask;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] rd_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(2), .XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_rd       (ld_rd),
        .ld_funct3   (ld_funct3),
        .ld_addr_lo  (ld_addr_lo),
        .ld_data     (ld_data),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .alu_stall   (alu_stall),
        .pend_mask   (pend_mask),
        .we          (we),
        .rd          (rd),
        .rd_data     (rd_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_funct3 = 3'b010; ld_addr_lo = '0; ld_data = '0;
        ld_issue = 1'b0; ld_issue_rd = '0;
    endtask

    task automatic drive_ld(input logic [4:0] r, input logic [2:0] f3,
                            input logic [1:0] lo, input logic [31:0] w);
        ld_valid = 1'b1; ld_rd = r; ld_funct3 = f3; ld_addr_lo = lo; ld_data = w;
    endtask

    // One load alone: enqueued on the first edge, written back on the second.
    task automatic load_one(input string tag, input logic [4:0] r, input logic [2:0] f3,
                            input logic [1:0] lo, input logic [31:0] w, input logic [31:0] exp);
        drive_ld(r, f3, lo, w);
        step();
        ld_valid = 1'b0;
        chk({tag, "_we_q"}, we, 0);
        step();
        chk({tag, "_we"}, we, 1);
        chk({tag, "_data"}, rd_data, exp);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        chk("rst_we", we, 0);
        chk("rst_rd", rd, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_pend", pend_mask, 0);
        chk("rst_ready", ld_ready, 1);
        chk("rst_stall", alu_stall, 0);
        rst_n = 1'b1;
        step();

        // ALU alone
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        step();
        alu_valid = 1'b0;
        chk("alu_we", we, 1);
        chk("alu_rd", rd, 5);
        chk("alu_data", rd_data, 32'h1234);
        step();
        chk("idle_we", we, 0);
        chk("idle_rd_hold", rd, 5);
        chk("idle_data_hold", rd_data, 32'h1234);

        // Extension cases
        load_one("lb",  5'd1, 3'b000, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80);
        load_one("lbu", 5'd1, 3'b100, 2'd3, 32'h80FF_0000, 32'h0000_0080);
        load_one("lh",  5'd2, 3'b001, 2'd2, 32'h8001_0000, 32'hFFFF_8001);
        load_one("lhu", 5'd2, 3'b101, 2'd0, 32'h1234_8765, 32'h0000_8765);
        load_one("lb1", 5'd2, 3'b000, 2'd1, 32'h0000_7F00, 32'h0000_007F);
        load_one("lw",  5'd2, 3'b010, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // ALU and load in the same cycle
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hAA;
        drive_ld(5'd4, 3'b010, 2'd0, 32'hBB);
        step();
        idle_inputs();
        chk("mix_alu_rd", rd, 3);
        chk("mix_alu_data", rd_data, 32'hAA);
        step();
        chk("mix_ld_we", we, 1);
        chk("mix_ld_rd", rd, 4);
        chk("mix_ld_data", rd_data, 32'hBB);
        step();

        // Fill FIFO behind back-to-back ALU results
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h10;
        drive_ld(5'd12, 3'b010, 2'd0, 32'h0C);
        step();
        chk("fill1_ready", ld_ready, 1);
        chk("fill1_rd", rd, 10);
        alu_rd = 5'd11; alu_data = 32'h11;
        drive_ld(5'd13, 3'b010, 2'd0, 32'h0D);
        step();
        idle_inputs();
        chk("full_ready", ld_ready, 0);
        chk("full_stall", alu_stall, 1);
        chk("full_rd", rd, 11);
        step();
        chk("drain1_rd", rd, 12);
        chk("drain1_data", rd_data, 32'h0C);
        chk("drain1_ready", ld_ready, 1);
        chk("drain1_stall", alu_stall, 0);
        step();
        chk("drain2_rd", rd, 13);
        chk("drain2_data", rd_data, 32'h0D);
        step();
        chk("drain_idle_we", we, 0);

        // Scoreboard set and clear
        ld_issue = 1'b1; ld_issue_rd = 5'd7;
        step();
        ld_issue = 1'b0;
        chk("sb_set", pend_mask, 32'h80);
        drive_ld(5'd7, 3'b010, 2'd0, 32'h77);
        step();
        ld_valid = 1'b0;
        chk("sb_queued", pend_mask, 32'h80);
        step();
        chk("sb_clr_we", we, 1);
        chk("sb_clr_rd", rd, 7);
        chk("sb_clr", pend_mask, 0);

        // Reissue to x7 in the cycle the earlier load retires
        ld_issue = 1'b1; ld_issue_rd = 5'd7;
        step();
        ld_issue = 1'b0;
        drive_ld(5'd7, 3'b010, 2'd0, 32'h78);
        step();
        ld_valid = 1'b0;
        ld_issue = 1'b1; ld_issue_rd = 5'd7;
        step();
        ld_issue = 1'b0;
        chk("sb_re_we", we, 1);
        chk("sb_re_data", rd_data, 32'h78);
        chk("sb_re_keep", pend_mask, 32'h80);
        drive_ld(5'd7, 3'b010, 2'd0, 32'h79);
        step();
        ld_valid = 1'b0;
        step();
        chk("sb_re_clr", pend_mask, 0);

        // x0 load: popped but never written
        ld_issue = 1'b1; ld_issue_rd = 5'd0;
        drive_ld(5'd0, 3'b010, 2'd0, 32'h55);
        step();
        idle_inputs();
        chk("x0_pend", pend_mask, 0);
        step();
        chk("x0_we", we, 0);

        // Two queued loads, then async reset mid-cycle
        ld_issue = 1'b1; ld_issue_rd = 5'd20;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9;
        drive_ld(5'd20, 3'b010, 2'd0, 32'h20);
        step();
        ld_issue = 1'b0;
        drive_ld(5'd21, 3'b010, 2'd0, 32'h21);
        step();
        idle_inputs();
        chk("pre_rst_full", alu_stall, 1);
        chk("pre_rst_pend", pend_mask, 32'h0010_0000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", we, 0);
        chk("mid_rst_pend", pend_mask, 0);
        chk("mid_rst_ready", ld_ready, 1);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_we", we, 0);
        chk("post_rst_stall", alu_stall, 0);
        step();
        chk("post_rst_we2", we, 0);
        chk("post_rst_rd", rd, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
